// File: rtl/processor_pkg.sv
// processor_pkg: shared constants, object geometry, colours, FSM state
// encoding and LFSR helpers for the cannon/laser/target game.
package processor_pkg;

    // Frame buffer geometry
    localparam logic [7:0] SCREEN_W      = 8'd160;
    localparam logic [6:0] SCREEN_H      = 7'd120;

    // Colours {R,G,B}
    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_CANNON  = 3'b010;
    localparam logic [2:0] COLOR_LASER   = 3'b100;
    localparam logic [2:0] COLOR_TARGET  = 3'b110;

    // Cannon: 8x2 on the bottom two rows
    localparam logic [7:0] CANNON_W      = 8'd8;
    localparam logic [6:0] CANNON_H      = 7'd2;
    localparam logic [6:0] CANNON_Y      = 7'd118;
    localparam logic [7:0] CANNON_X_MAX  = 8'd152;
    localparam logic [7:0] CANNON_X_INIT = 8'd76;

    // Laser: 1x4, spawns above the cannon centre, climbs 2 px per tick
    localparam logic [7:0] LASER_W       = 8'd1;
    localparam logic [6:0] LASER_H       = 7'd4;
    localparam logic [6:0] LASER_Y_SPAWN = 7'd114;
    localparam logic [7:0] LASER_X_OFS   = 8'd3;
    localparam logic [6:0] LASER_STEP    = 7'd2;

    // Target: 4x4, falls 1 px per tick
    localparam logic [7:0] TARGET_W      = 8'd4;
    localparam logic [6:0] TARGET_H      = 7'd4;
    localparam logic [6:0] TARGET_Y_MAX  = 7'd114;
    localparam logic [7:0] TARGET_X_INIT = 8'd76;

    // Respawn column generator
    localparam logic [7:0] LFSR_SEED     = 8'hA5;
    localparam logic [7:0] RESPAWN_LIMIT = 8'd156;
    localparam logic [7:0] RESPAWN_ADJ   = 8'd100;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WAIT_TICK,
        ERASE,
        UPDATE,
        DRAW
    } state_t;

    typedef enum logic [1:0] {
        OBJ_CANNON,
        OBJ_LASER,
        OBJ_TARGET
    } obj_t;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Fold the LFSR value into a column where the 4-wide target fits
    function automatic logic [7:0] respawn_x(input logic [7:0] q);
        return (q < RESPAWN_LIMIT) ? q : q - RESPAWN_ADJ;
    endfunction

endpackage

// File: rtl/rect_plotter.sv
// rect_plotter: walks a w x h rectangle row-major, one pixel per cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : latch x/y/w/h/colour and begin (restarts if busy)
//   x, y, w, h, colour: rectangle origin, size (w,h >= 1) and colour
//   px_valid          : a pixel is presented this cycle (equals busy)
//   px_x, px_y        : pixel coordinates
//   px_colour         : pixel colour
//   done              : high together with the last pixel of the rectangle
//   busy              : rectangle in progress
module rect_plotter
    import processor_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [7:0] w,
    input  logic [6:0] h,
    input  logic [2:0] colour,
    output logic       px_valid,
    output logic [7:0] px_x,
    output logic [6:0] px_y,
    output logic [2:0] px_colour,
    output logic       done,
    output logic       busy
);

    logic [7:0] base_x, size_w, cx;
    logic [6:0] base_y, size_h, cy;
    logic [2:0] colour_q;
    logic       last_col, last_row;

    assign last_col  = (cx == size_w - 8'd1);
    assign last_row  = (cy == size_h - 7'd1);
    assign px_valid  = busy;
    assign px_x      = base_x + cx;
    assign px_y      = base_y + cy;
    assign px_colour = colour_q;
    assign done      = busy && last_col && last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            base_x   <= '0;
            base_y   <= '0;
            size_w   <= '0;
            size_h   <= '0;
            colour_q <= COLOR_BLACK;
        end else if (start) begin
            busy     <= 1'b1;
            cx       <= '0;
            cy       <= '0;
            base_x   <= x;
            base_y   <= y;
            size_w   <= w;
            size_h   <= h;
            colour_q <= colour;
        end else if (busy) begin
            if (last_col) begin
                cx <= '0;
                if (last_row) begin
                    busy <= 1'b0;
                end else begin
                    cy <= cy + 7'd1;
                end
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/processor.sv
// processor: cannon / laser / target game driving a 160x120 frame buffer.
//   TICK_CYCLES  : clk cycles per game tick (>= 2)
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   game_start   : 1 = run, 0 = pause (takes effect at the end of a tick)
//   right_button : move cannon right
//   left_button  : move cannon left
//   plot_x/plot_y/color/plot : registered pixel write port
// Build option: define PROCESSOR_WRAP_EN to make the cannon wrap between
// x=0 and x=152 instead of clamping at those edges.
module processor
    import processor_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic       right_button,
    input  logic       left_button,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] color,
    output logic       plot
);

    localparam int unsigned       TICK_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

`ifdef PROCESSOR_WRAP_EN
    localparam logic [7:0] RIGHT_EDGE_NEXT = '0;
    localparam logic [7:0] LEFT_EDGE_NEXT  = CANNON_X_MAX;
`else
    localparam logic [7:0] RIGHT_EDGE_NEXT = CANNON_X_MAX;
    localparam logic [7:0] LEFT_EDGE_NEXT  = '0;
`endif

    state_t            state, state_next;
    obj_t              obj, obj_next;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_done;

    // Game objects
    logic [7:0] cannon_x, laser_x, target_x, lfsr;
    logic [6:0] laser_y, target_y;
    logic       laser_on;

    // Rectangle plotter interface
    logic       rect_start, rect_done, rect_busy;
    logic [7:0] rect_x, rect_w;
    logic [6:0] rect_y, rect_h;
    logic [2:0] rect_colour;
    logic       px_valid;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;

    assign tick_done = (tick_cnt == TICK_LAST);

    rect_plotter u_rect (
        .clk       (clk),
        .rst_n     (reset),
        .start     (rect_start),
        .x         (rect_x),
        .y         (rect_y),
        .w         (rect_w),
        .h         (rect_h),
        .colour    (rect_colour),
        .px_valid  (px_valid),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_colour (px_colour),
        .done      (rect_done),
        .busy      (rect_busy)
    );

    // Geometry of the rectangle for the current state/object
    always_comb begin
        rect_x      = '0;
        rect_y      = '0;
        rect_w      = SCREEN_W;
        rect_h      = SCREEN_H;
        rect_colour = COLOR_BLACK;
        if (state != CLEAR) begin
            case (obj)
                OBJ_CANNON: begin
                    rect_x      = cannon_x;
                    rect_y      = CANNON_Y;
                    rect_w      = CANNON_W;
                    rect_h      = CANNON_H;
                    rect_colour = COLOR_CANNON;
                end
                OBJ_LASER: begin
                    rect_x      = laser_x;
                    rect_y      = laser_y;
                    rect_w      = LASER_W;
                    rect_h      = LASER_H;
                    rect_colour = COLOR_LASER;
                end
                default: begin
                    rect_x      = target_x;
                    rect_y      = target_y;
                    rect_w      = TARGET_W;
                    rect_h      = TARGET_H;
                    rect_colour = COLOR_TARGET;
                end
            endcase
            if (state != DRAW) begin
                rect_colour = COLOR_BLACK;
            end
        end
    end

    // Next-state logic. Plotting states launch a rectangle whenever the
    // plotter is idle; rect_done advances to the next object, skipping the
    // laser while it is inactive.
    always_comb begin
        state_next = state;
        obj_next   = obj;
        rect_start = 1'b0;
        case (state)
            CLEAR: begin
                rect_start = !rect_busy;
                if (rect_done) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (game_start) begin
                    state_next = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick_done) begin
                    state_next = game_start ? ERASE : IDLE;
                    obj_next   = OBJ_CANNON;
                end
            end
            ERASE, DRAW: begin
                rect_start = !rect_busy;
                if (rect_done) begin
                    case (obj)
                        OBJ_CANNON: obj_next = laser_on ? OBJ_LASER : OBJ_TARGET;
                        OBJ_LASER:  obj_next = OBJ_TARGET;
                        default: begin
                            obj_next   = OBJ_CANNON;
                            state_next = (state == ERASE) ? UPDATE : WAIT_TICK;
                        end
                    endcase
                end
            end
            UPDATE: begin
                state_next = DRAW;
                obj_next   = OBJ_CANNON;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            obj      <= OBJ_CANNON;
            tick_cnt <= '0;
        end else begin
            state    <= state_next;
            obj      <= obj_next;
            tick_cnt <= (state == WAIT_TICK && !tick_done) ? tick_cnt + 1'b1 : '0;
        end
    end

    // Per-tick game update
    logic [7:0] cannon_upd, laser_x_mv, target_x_mv, lfsr_upd, spawn_x;
    logic [6:0] laser_y_mv, target_y_mv;
    logic       laser_on_mv, hit;

    always_comb begin
        cannon_upd = cannon_x;
        if (right_button && !left_button) begin
            cannon_upd = (cannon_x == CANNON_X_MAX) ? RIGHT_EDGE_NEXT : cannon_x + 8'd1;
        end else if (left_button && !right_button) begin
            cannon_upd = (cannon_x == '0) ? LEFT_EDGE_NEXT : cannon_x - 8'd1;
        end

        laser_on_mv = laser_on;
        laser_x_mv  = laser_x;
        laser_y_mv  = laser_y;
        if (!laser_on) begin
            laser_on_mv = 1'b1;
            laser_x_mv  = cannon_upd + LASER_X_OFS;
            laser_y_mv  = LASER_Y_SPAWN;
        end else if (laser_y < LASER_STEP) begin
            laser_on_mv = 1'b0;
        end else begin
            laser_y_mv = laser_y - LASER_STEP;
        end

        lfsr_upd = lfsr_step(lfsr);
        spawn_x  = respawn_x(lfsr_upd);

        target_x_mv = target_x;
        target_y_mv = target_y + 7'd1;
        if (target_y >= TARGET_Y_MAX) begin
            target_x_mv = spawn_x;
            target_y_mv = '0;
        end

        // Axis-aligned overlap, evaluated on post-move positions; widened
        // by one bit so the far-edge sums cannot wrap.
        hit = laser_on_mv
            && ({1'b0, laser_x_mv} <= {1'b0, target_x_mv} + {1'b0, TARGET_W} - 9'd1)
            && ({1'b0, target_x_mv} <= {1'b0, laser_x_mv} + {1'b0, LASER_W} - 9'd1)
            && ({1'b0, laser_y_mv} <= {1'b0, target_y_mv} + {1'b0, TARGET_H} - 8'd1)
            && ({1'b0, target_y_mv} <= {1'b0, laser_y_mv} + {1'b0, LASER_H} - 8'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cannon_x <= CANNON_X_INIT;
            laser_on <= 1'b0;
            laser_x  <= '0;
            laser_y  <= '0;
            target_x <= TARGET_X_INIT;
            target_y <= '0;
            lfsr     <= LFSR_SEED;
        end else if (state == UPDATE) begin
            cannon_x <= cannon_upd;
            laser_x  <= laser_x_mv;
            laser_y  <= laser_y_mv;
            lfsr     <= lfsr_upd;
            if (hit) begin
                laser_on <= 1'b0;
                target_x <= spawn_x;
                target_y <= '0;
            end else begin
                laser_on <= laser_on_mv;
                target_x <= target_x_mv;
                target_y <= target_y_mv;
            end
        end
    end

    // Registered pixel write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plot   <= 1'b0;
            plot_x <= '0;
            plot_y <= '0;
            color  <= COLOR_BLACK;
        end else begin
            plot   <= px_valid;
            plot_x <= px_x;
            plot_y <= px_y;
            color  <= px_colour;
        end
    end

endmodule

// File: tb/tb_processor.sv
// tb_processor: directed checks of the processor game with TICK_CYCLES=4.
// Each frame's plot stream is reduced to per-colour pixel counts and
// bounding boxes, which are compared with hand-derived positions.
module tb_processor;

    localparam int unsigned TICKS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_start;
    logic       right_button;
    logic       left_button;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] color;
    logic       plot;

    always #5 clk = ~clk;

    processor #(.TICK_CYCLES(TICKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .game_start   (game_start),
        .right_button (right_button),
        .left_button  (left_button),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .color        (color),
        .plot         (plot)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int cnt   [8];
    int min_x [8];
    int max_x [8];
    int min_y [8];
    int max_y [8];
    int last_x, last_y, order_err;

    logic [7:0] lfsr_m;
    int         rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] q);
        logic fb;
        fb = q[7] ^ q[5] ^ q[4] ^ q[3];
        return {q[6:0], fb};
    endfunction

    // Collect one burst of plot pulses (ends after 3 quiet cycles)
    task automatic capture(input int limit, input bit row_major);
        int waited = 0;
        int idle   = 0;
        int k      = 0;
        bit seen   = 1'b0;
        bit stop   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cnt[c]   = 0;
            min_x[c] = 999;
            max_x[c] = -1;
            min_y[c] = 999;
            max_y[c] = -1;
        end
        order_err = 0;
        last_x    = -1;
        last_y    = -1;
        while (!stop) begin
            @(negedge clk);
            waited++;
            if (plot === 1'b1) begin
                seen = 1'b1;
                idle = 0;
                cnt[color]++;
                if (int'(plot_x) < min_x[color]) min_x[color] = int'(plot_x);
                if (int'(plot_x) > max_x[color]) max_x[color] = int'(plot_x);
                if (int'(plot_y) < min_y[color]) min_y[color] = int'(plot_y);
                if (int'(plot_y) > max_y[color]) max_y[color] = int'(plot_y);
                last_x = int'(plot_x);
                last_y = int'(plot_y);
                if (row_major && (int'(plot_x) != k % 160 || int'(plot_y) != k / 160))
                    order_err++;
                k++;
            end else if (seen) begin
                idle++;
                if (idle >= 3) stop = 1'b1;
            end
            if (!stop && waited >= limit) stop = 1'b1;
        end
        check("burst_complete", {31'd0, seen && idle >= 3}, 32'd1);
    endtask

    task automatic check_obj(input string tag, input int c, input int n,
                             input int x0, input int x1, input int y0, input int y1);
        check({tag, "_count"}, cnt[c], n);
        if (n > 0) begin
            check({tag, "_xmin"}, min_x[c], x0);
            check({tag, "_xmax"}, max_x[c], x1);
            check({tag, "_ymin"}, min_y[c], y0);
            check({tag, "_ymax"}, max_y[c], y1);
        end
    endtask

    task automatic frame(input bit l, input bit r);
        left_button  = l;
        right_button = r;
        capture(400, 1'b0);
        lfsr_m = model_lfsr(lfsr_m);
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_black_pixels"}, cnt[0], 19200);
        check({tag, "_coloured_pixels"}, cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5] + cnt[6] + cnt[7], 0);
        check({tag, "_order_errors"}, order_err, 0);
        check({tag, "_last_x"}, last_x, 159);
        check({tag, "_last_y"}, last_y, 119);
    endtask

    task automatic check_first_frame(input string tag);
        check({tag, "_erase"}, cnt[0], 32);
        check_obj({tag, "_cannon"}, 2, 16, 76, 83, 118, 119);
        check_obj({tag, "_laser"},  4, 4,  79, 79, 114, 117);
        check_obj({tag, "_target"}, 6, 16, 76, 79, 1, 4);
    endtask

    initial begin
        int quiet;
        int w;
        int exp_x;

        reset        = 1'b0;
        game_start   = 1'b0;
        right_button = 1'b0;
        left_button  = 1'b0;
        lfsr_m       = 8'hA5;

        repeat (3) @(negedge clk);
        check("reset_plot",   {31'd0, plot},   32'd0);
        check("reset_plot_x", {24'd0, plot_x}, 32'd0);
        check("reset_plot_y", {25'd0, plot_y}, 32'd0);
        check("reset_color",  {29'd0, color},  32'd0);

        // Screen clear after release
        reset = 1'b1;
        capture(25000, 1'b1);
        check_clear("clear");

        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (plot === 1'b1) quiet++;
        end
        check("idle_plots", quiet, 0);

        // Tick 1: cannon at 76, laser spawns at 79, target falls to y=1
        game_start = 1'b1;
        frame(1'b0, 1'b0);
        check_first_frame("f1");

        // Ticks 2-6: both buttons, cannon stays
        for (int i = 2; i <= 6; i++) frame(1'b1, 1'b1);
        check("f6_erase", cnt[0], 36);
        check_obj("f6_cannon", 2, 16, 76, 83, 118, 119);
        check_obj("f6_laser",  4, 4,  79, 79, 104, 107);

        // Ticks 7-16: left, cannon 76 -> 66
        for (int i = 7; i <= 16; i++) frame(1'b1, 1'b0);
        check_obj("f16_cannon", 2, 16, 66, 73, 118, 119);
        check_obj("f16_laser",  4, 4,  79, 79, 84, 87);
        check_obj("f16_target", 6, 16, 76, 79, 16, 19);

        // Ticks 17-37: laser and target approach each other
        for (int i = 17; i <= 37; i++) frame(1'b0, 1'b0);
        check_obj("f37_laser",  4, 4,  79, 79, 42, 45);
        check_obj("f37_target", 6, 16, 76, 79, 37, 40);

        // Tick 38: laser y 40..43 meets target y 38..41 -> hit
        frame(1'b0, 1'b0);
        rx = (lfsr_m < 8'd156) ? int'(lfsr_m) : int'(lfsr_m) - 100;
        check("f38_erase", cnt[0], 36);
        check_obj("f38_cannon", 2, 16, 66, 73, 118, 119);
        check_obj("f38_laser",  4, 0,  0, 0, 0, 0);
        check_obj("f38_target", 6, 16, rx, rx + 3, 0, 3);

        // Tick 39: nothing stale to erase, fresh laser above the cannon
        frame(1'b0, 1'b0);
        check("f39_erase", cnt[0], 32);
        check_obj("f39_laser",  4, 4,  69, 69, 114, 117);
        check_obj("f39_target", 6, 16, rx, rx + 3, 1, 4);

        // Ticks 40-105 bring the cannon to 0; tick 106 pushes past the edge
        for (int i = 40; i <= 106; i++) frame(1'b1, 1'b0);
`ifdef PROCESSOR_WRAP_EN
        exp_x = 152;
`else
        exp_x = 0;
`endif
        check_obj("f106_cannon", 2, 16, exp_x, exp_x + 7, 118, 119);
        frame(1'b1, 1'b0);
`ifdef PROCESSOR_WRAP_EN
        exp_x = 151;
`else
        exp_x = 0;
`endif
        check_obj("f107_cannon", 2, 16, exp_x, exp_x + 7, 118, 119);

        // Pause: no plotting, then resume with the cannon where it was
        game_start = 1'b0;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (plot === 1'b1) quiet++;
        end
        check("pause_plots", quiet, 0);
        game_start = 1'b1;
        frame(1'b0, 1'b0);
        check_obj("resume_cannon", 2, 16, exp_x, exp_x + 7, 118, 119);

        // Reset in the middle of a frame aborts at once
        w = 0;
        while (plot !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("midframe_reached", {31'd0, plot}, 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_plot",   {31'd0, plot},   32'd0);
        check("abort_plot_x", {24'd0, plot_x}, 32'd0);
        check("abort_color",  {29'd0, color},  32'd0);
        @(negedge clk);
        reset  = 1'b1;
        lfsr_m = 8'hA5;
        capture(25000, 1'b1);
        check_clear("reclear");
        frame(1'b0, 1'b0);
        check_first_frame("rf1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
